// File: rtl/crc_framed_pkg.sv
// crc_framed_pkg: shared FSM encoding, framing bit values and default CRC polynomials
// for the framed serial CRC engine.
package crc_framed_pkg;
    typedef enum logic [1:0] {DATA, CRC, DONE} state_t;
    localparam logic [15:0] CRC16_POLY = 16'h8005;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;
    localparam logic [7:0]  CRC8_POLY  = 8'h07;
    localparam logic [7:0]  CRC8_INIT  = 8'h00;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
endpackage

// File: rtl/crc_framed_engine_bit_step.sv
// crc_bit_step: one-bit Galois LFSR update, MSB-first, polynomial given without the top term.
module crc_bit_step #(
    parameter int CRC_W = 16,
    parameter logic [CRC_W-1:0] POLY = 16'h8005
) (
    input  logic [CRC_W-1:0] i_crc,
    input  logic             i_bit,
    output logic [CRC_W-1:0] o_crc
);
    logic w_fb;
    assign w_fb  = i_crc[CRC_W-1] ^ i_bit;
    assign o_crc = {i_crc[CRC_W-2:0], 1'b0} ^ ({CRC_W{w_fb}} & POLY);
endmodule

// File: rtl/crc_framed_engine.sv
// crc_framed_engine: serial CRC generator/checker over framed symbols (start 0, payload
// MSB-first, stop 1); appends or verifies NSYM framed CRC symbols after the payload.
module crc_framed_engine
    import crc_framed_pkg::*;
#(
    parameter int CRC_W = 16,
    parameter logic [CRC_W-1:0] POLY = CRC16_POLY,
    parameter logic [CRC_W-1:0] INIT = CRC16_INIT,
    parameter int SYM_BITS = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             mode,
    input  logic             crc_phase,
    input  logic             data_in,
    output logic             data_out,
    output logic [CRC_W-1:0] crc_value,
    output logic             done,
    output logic             crc_err,
    output logic             frame_err
);
    localparam int DATA_BITS = SYM_BITS - 2;
    localparam int NSYM = CRC_W / DATA_BITS;
    localparam int CW = $clog2(SYM_BITS);
    localparam int SW = (NSYM > 1) ? $clog2(NSYM) : 1;
    localparam logic [CW-1:0] LAST = CW'(SYM_BITS - 1);
    localparam logic [SW-1:0] SYM_LAST = SW'(NSYM - 1);

    state_t r_st, w_st_nx;
    logic [CW-1:0] r_cnt;
    logic [SW-1:0] r_sym;
    logic [CRC_W-1:0] r_crc, r_crc_value, w_step;
    logic r_done, r_crc_err, r_frame_err;
    logic w_last, w_pay, w_sym_last, w_to_crc;

    assign w_last     = r_cnt == LAST;
    assign w_pay      = r_cnt != '0 && !w_last;
    assign w_sym_last = r_sym == SYM_LAST;
    assign w_to_crc   = r_st == DATA && w_last && crc_phase;

    crc_bit_step #(.CRC_W(CRC_W), .POLY(POLY)) u_step (
        .i_crc(r_crc),
        .i_bit(data_in),
        .o_crc(w_step)
    );

    always_comb begin
        w_st_nx = r_st;
        w_st_nx = w_to_crc ? CRC : (r_st == CRC && w_last && w_sym_last) ? DONE : r_st;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_st <= DATA;
        else if (!enable) r_st <= DATA;
        else r_st <= w_st_nx;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
            r_sym <= '0;
            r_crc <= INIT;
            r_crc_value <= '0;
            r_done <= 1'b0;
            r_crc_err <= 1'b0;
            r_frame_err <= 1'b0;
        end else if (!enable) begin
            r_cnt <= '0;
            r_sym <= '0;
            r_crc <= INIT;
            r_crc_value <= '0;
            r_done <= 1'b0;
            r_crc_err <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_cnt <= (r_st == DONE || w_last) ? '0 : r_cnt + 1'b1;
            if (w_to_crc) begin
                r_sym <= '0;
                r_crc_value <= r_crc;
            end
            if (r_st == CRC && w_last && !w_sym_last) r_sym <= r_sym + 1'b1;
            // After the payload the register is drained MSB-first as the CRC symbols.
            if (w_pay && r_st != DONE) r_crc <= (r_st == DATA) ? w_step : {r_crc[CRC_W-2:0], 1'b0};
            if (mode && r_st == CRC && w_pay && data_in != r_crc[CRC_W-1]) r_crc_err <= 1'b1;
            if (mode && r_st != DONE && ((r_cnt == '0 && data_in != START_BIT) || (w_last && data_in != STOP_BIT)))
                r_frame_err <= 1'b1;
            r_done <= r_st == CRC && w_last && w_sym_last;
        end
    end

    assign data_out  = (!mode && r_st == CRC) ? (r_cnt == '0 ? START_BIT : w_last ? STOP_BIT : r_crc[CRC_W-1]) : 1'b0;
    assign crc_value = r_crc_value;
    assign done      = r_done;
    assign crc_err   = r_crc_err;
    assign frame_err = r_frame_err;
endmodule
